gi_banked_mem: RTL
==================

Name: gi_banked_mem

Overview:
Parametrised multi-channel on-chip buffer for guided-filter intermediates: the ak/bk window store and per-stripe line data.
- Generalises the single-bank immediate-read, delayed-write memory model to NUM_CH independent banks.
- Read latency is selectable: 0 (combinational) or 1 (registered).
- Clearing is done by a hardware sweep FSM instead of a one-cycle array reset, so the block maps to real SRAM.

Parameters:
- DATA_W, 32, bits per word (ak+bk packed = 5+A_FRACBITS+13+B_FRACBITS).
- DEPTH, 4650, words per bank ((2*ALPHA+1)*(STRIPEWIDTH+2*ALPHA)).
- NUM_CH, 2, number of independent banks/channels.
- RD_LAT, 1, read latency in cycles; legal values 0 or 1.
- ADDR_W, $clog2(DEPTH), address width per channel.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- clr_req  in  1  one-cycle pulse requesting a full clear of all banks.
- clr_busy  out  1  high while the clear sweep runs.
- wen  in  NUM_CH  per-channel write enable.
- waddr  in  NUM_CH*ADDR_W  per-channel write address; channel c occupies bits [c*ADDR_W +: ADDR_W].
- wdata  in  NUM_CH*DATA_W  per-channel write data.
- ren  in  NUM_CH  per-channel read enable.
- raddr  in  NUM_CH*ADDR_W  per-channel read address.
- rdata  out  NUM_CH*DATA_W  per-channel read data.
- rvalid  out  NUM_CH  per-channel read-data-valid.

Behaviour:
- Clock is clk; reset is asynchronous and active-high.
- Reset values: clr_busy=1, rdata=0, rvalid=0, FSM in CLEAR, sweep counter=0.
- FSM states: CLEAR, RUN.
  - Leaving reset: CLEAR.
  - CLEAR: one zero word is written per cycle at address cnt in every bank. cnt runs 0..DEPTH-1.
  - When cnt==DEPTH-1 the FSM moves to RUN. clr_busy is low from the next cycle, so a sweep lasts exactly DEPTH cycles.
  - RUN with clr_req=1: go to CLEAR with cnt=0. clr_busy rises on the following edge.
  - clr_req during CLEAR restarts cnt at 0.
  - reset asserted mid-sweep returns to the reset values immediately (asynchronous).
- Writes are accepted only in RUN:
  - ram[c][waddr_c] <= wdata_c on the rising edge when wen[c]=1.
  - Writes during CLEAR are dropped silently.
- Reads:
  - RD_LAT=0: rdata_c = (ren[c] && RUN && raddr_c<DEPTH) ? ram[c][raddr_c] : 0, purely combinational; rvalid[c] = ren[c] && RUN.
  - RD_LAT=1: both rdata_c and rvalid[c] are registered one cycle after ren[c] is sampled. rdata holds its last value when ren=0.
- Out of range (address >= DEPTH, when DEPTH is not a power of two):
  - write is ignored;
  - read returns 0 with rvalid still asserted.
- Same channel, same address, same cycle, read and write: read-first. rdata returns the pre-write word in both latency modes, unless the optional feature below is enabled.
- Channels are fully independent: no cross-channel arbitration or ordering.
- No wrap-around addressing; callers compute circular row addresses.

Optional Feature:
- Macro: GI_MEM_BYPASS_EN.
- Defined: write-to-read forwarding. A same-cycle, same-channel, same-address collision in RUN returns wdata_c instead of the stored word, in both RD_LAT modes.
- Undefined: read-first behaviour as above. No forwarding comparators are instantiated.

Decomposition:
- Shared package gi_mem_pkg holds:
  - state typedef (CLEAR, RUN);
  - RD_LAT legal-value constants;
  - default ALPHA/STRIPEWIDTH-derived DEPTH and DATA_W constants;
  - a clog2 helper function.
- Sub-module gi_mem_bank: one single-port-write, single-port-read array plus read/bypass logic, instantiated NUM_CH times in a generate loop.
- The clear FSM and sweep counter live once in the top, and drive each bank's write port while in CLEAR.

Test Plan:
- Reset release, DEPTH=8, NUM_CH=2 -> clr_busy high exactly 8 cycles after reset deasserts, then low; reads at addr 0..7 on both channels return 0.
- RUN, RD_LAT=1, write ch0 addr 3 = 0xA5A5A5A5, read it next cycle -> rdata ch0 = 0xA5A5A5A5 with rvalid=1 one cycle after ren; ch1 addr 3 still reads 0.
- ch1 addr 5 holds 0x11; same cycle write 0x22 and read addr 5 -> rdata 0x11 without GI_MEM_BYPASS_EN, 0x22 with it; the following read returns 0x22 in both builds.
- Fill all addresses, pulse clr_req, issue wen during busy -> clr_busy high 8 cycles, rvalid=0 during sweep, all reads return 0 afterwards, busy-time writes absent.
- Assert reset at sweep cycle 4 -> clr_busy=1 and rdata=0 asynchronously; sweep restarts and completes 8 cycles after release.
- DEPTH=6 (ADDR_W=3), write addr 7 = 0xFF, read addr 7 -> write ignored, rdata=0, rvalid=1; addr 0..5 unchanged.

Source files
------------

// File: rtl/gi_mem_pkg.sv
// Shared types and constants for the guided-filter banked buffer.
// Default sizes derive from the ak/bk window geometry and fixed-point packing.
package gi_mem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } mem_state_t;

    localparam int unsigned RD_LAT_COMB = 0;
    localparam int unsigned RD_LAT_REG  = 1;

    localparam int unsigned ALPHA       = 15;
    localparam int unsigned STRIPEWIDTH = 120;
    localparam int unsigned A_FRACBITS  = 7;
    localparam int unsigned B_FRACBITS  = 7;

    localparam int unsigned DEF_DEPTH  = (2 * ALPHA + 1) * (STRIPEWIDTH + 2 * ALPHA);
    localparam int unsigned DEF_DATA_W = 5 + A_FRACBITS + 13 + B_FRACBITS;

    function automatic int unsigned gi_clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/gi_banked_mem_if.sv
// Request/response bundle of the banked buffer: clear control plus per-channel
// write and read ports packed channel-major.
interface gi_banked_mem_if
    import gi_mem_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = gi_clog2(DEF_DEPTH)
);
    logic                     clr_req;
    logic                     clr_busy;
    logic [NUM_CH-1:0]        wen;
    logic [NUM_CH*ADDR_W-1:0] waddr;
    logic [NUM_CH*DATA_W-1:0] wdata;
    logic [NUM_CH-1:0]        ren;
    logic [NUM_CH*ADDR_W-1:0] raddr;
    logic [NUM_CH*DATA_W-1:0] rdata;
    logic [NUM_CH-1:0]        rvalid;

    modport master (
        output clr_req, wen, waddr, wdata, ren, raddr,
        input  clr_busy, rdata, rvalid
    );

    modport slave (
        input  clr_req, wen, waddr, wdata, ren, raddr,
        output clr_busy, rdata, rvalid
    );

endinterface

// File: rtl/gi_mem_bank.sv
// One buffer bank: read-first single write / single read array with
// selectable read latency; GI_MEM_BYPASS_EN adds same-address write forwarding.
module gi_mem_bank
    import gi_mem_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned ADDR_W = gi_clog2(DEF_DEPTH),
    parameter int unsigned RD_LAT = RD_LAT_REG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_run,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rvalid
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_wr_ok;
    logic              w_rd_ok;
    logic              w_hit;
    logic [DATA_W-1:0] w_rd_word;

    // Non-power-of-two depths leave a hole at the top of the address space.
    assign w_wr_ok = i_we && (32'(i_waddr) < DEPTH);
    assign w_rd_ok = i_re && i_run && (32'(i_raddr) < DEPTH);

    always_ff @(posedge clk) begin
        if (w_wr_ok) r_mem[i_waddr] <= i_wdata;
    end

`ifdef GI_MEM_BYPASS_EN
    assign w_hit = i_run && i_we && (i_waddr == i_raddr);
`else
    assign w_hit = 1'b0;
`endif

    always_comb begin
        w_rd_word = '0;
        if (w_rd_ok) w_rd_word = w_hit ? i_wdata : r_mem[i_raddr];
    end

    generate
        if (RD_LAT == RD_LAT_REG) begin : g_reg
            logic [DATA_W-1:0] r_rdata;
            logic              r_rvalid;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rdata  <= '0;
                    r_rvalid <= 1'b0;
                end else begin
                    r_rvalid <= i_re && i_run;
                    if (i_re) r_rdata <= w_rd_word;
                end
            end

            assign o_rdata  = r_rdata;
            assign o_rvalid = r_rvalid;
        end else begin : g_comb
            assign o_rdata  = w_rd_word;
            assign o_rvalid = i_re && i_run;
        end
    endgenerate

endmodule

// File: rtl/gi_banked_mem.sv
// NUM_CH independent buffer banks sharing one zero-fill sweep FSM.
// Define GI_MEM_BYPASS_EN for same-cycle write-to-read forwarding.
module gi_banked_mem
    import gi_mem_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned RD_LAT = RD_LAT_REG,
    parameter int unsigned ADDR_W = gi_clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    gi_banked_mem_if.slave bus
);
    mem_state_t        r_state;
    mem_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              w_clearing;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_CLEAR: begin
                if (bus.clr_req) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == ADDR_W'(DEPTH - 1)) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                if (bus.clr_req) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
        endcase
    end

    always_comb begin
        w_clearing = (r_state == ST_CLEAR);
    end

    assign bus.clr_busy = w_clearing;

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            logic              w_we;
            logic [ADDR_W-1:0] w_waddr;
            logic [DATA_W-1:0] w_wdata;

            // The sweep owns every write port while clearing; user writes are dropped.
            assign w_we    = w_clearing | bus.wen[c];
            assign w_waddr = w_clearing ? r_cnt : bus.waddr[c*ADDR_W +: ADDR_W];
            assign w_wdata = w_clearing ? '0 : bus.wdata[c*DATA_W +: DATA_W];

            gi_mem_bank #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH),
                .ADDR_W (ADDR_W),
                .RD_LAT (RD_LAT)
            ) u_bank (
                .clk      (clk),
                .rst      (reset),
                .i_run    (!w_clearing),
                .i_we     (w_we),
                .i_waddr  (w_waddr),
                .i_wdata  (w_wdata),
                .i_re     (bus.ren[c]),
                .i_raddr  (bus.raddr[c*ADDR_W +: ADDR_W]),
                .o_rdata  (bus.rdata[c*DATA_W +: DATA_W]),
                .o_rvalid (bus.rvalid[c])
            );
        end
    endgenerate

endmodule
